// File: rtl/lcd_pkg.sv
// lcd_pkg: sequencer states, nibble-engine phases and HD44780 command
// constants shared by lcd_nibble_tx and lcd_char_writer.
package lcd_pkg;

   localparam int CNT_W = 20;

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT_NIB,
      INIT_CFG,
      IDLE,
      SEND_HI,
      SEND_LO,
      WAIT
   } lcd_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SU,
      TX_E,
      TX_GAP
   } tx_phase_t;

   localparam logic [3:0] NIB_INIT3 = 4'h3;
   localparam logic [3:0] NIB_INIT2 = 4'h2;

   localparam logic [7:0] CMD_FUNC  = 8'h28;
   localparam logic [7:0] CMD_ENTRY = 8'h06;
   localparam logic [7:0] CMD_DISP  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR = 8'h01;

   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;

   function automatic logic [7:0] cfg_cmd(input logic [1:0] i);
      logic [7:0] c;
      case (i)
         2'd0:    c = CMD_FUNC;
         2'd1:    c = CMD_ENTRY;
         2'd2:    c = CMD_DISP;
         default: c = CMD_CLEAR;
      endcase
      return c;
   endfunction

   // Clear and return-home need the long execution time
   function automatic logic is_slow(input logic [7:0] b);
      return (b == 8'h01) || (b == 8'h02);
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: one HD44780 nibble frame (setup, E pulse, gap) with a
// one-cycle done pulse in the last gap cycle so frames can chain back to back.
module lcd_nibble_tx
   import lcd_pkg::*;
#(
   parameter int T_SU = 2,
   parameter int T_E  = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [3:0]       i_nib,
   input  logic             i_rs,
   input  logic [CNT_W-1:0] i_gap,
   output logic             o_done,
   output logic             o_gap,
   output logic [3:0]       o_d,
   output logic             o_e,
   output logic             o_rs
);

   localparam logic [CNT_W-1:0] SU_LD = CNT_W'(T_SU - 1);
   localparam logic [CNT_W-1:0] E_LD  = CNT_W'(T_E - 1);

   tx_phase_t        r_phase;
   tx_phase_t        w_phase;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0] r_gap_ld;
   logic [3:0]       r_nib;
   logic             r_rs;
   logic             w_cnt_end;

   assign w_cnt_end = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= TX_IDLE;
         r_cnt   <= '0;
      end else begin
         r_phase <= w_phase;
         r_cnt   <= w_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_nib    <= '0;
         r_rs     <= 1'b0;
         r_gap_ld <= '0;
      end else if (i_start) begin
         r_nib    <= i_nib;
         r_rs     <= i_rs;
         r_gap_ld <= i_gap - CNT_W'(1);
      end
   end

   always_comb begin
      w_phase = r_phase;
      w_cnt   = r_cnt;
      if (i_start) begin
         w_phase = TX_SU;
         w_cnt   = SU_LD;
      end else begin
         unique case (r_phase)
            TX_SU: begin
               if (w_cnt_end) begin
                  w_phase = TX_E;
                  w_cnt   = E_LD;
               end else begin
                  w_cnt = r_cnt - CNT_W'(1);
               end
            end
            TX_E: begin
               if (w_cnt_end) begin
                  w_phase = TX_GAP;
                  w_cnt   = r_gap_ld;
               end else begin
                  w_cnt = r_cnt - CNT_W'(1);
               end
            end
            TX_GAP: begin
               if (w_cnt_end) w_phase = TX_IDLE;
               else           w_cnt   = r_cnt - CNT_W'(1);
            end
            default: w_phase = TX_IDLE;
         endcase
      end
   end

   always_comb begin
      o_done = (r_phase == TX_GAP) && w_cnt_end;
      o_gap  = (r_phase == TX_GAP);
      o_e    = (r_phase == TX_E);
      o_d    = r_nib;
      o_rs   = r_rs;
   end

endmodule

// File: rtl/lcd_char_writer.sv
// lcd_char_writer: HD44780 4-bit write-only sequencer with valid/ready input.
// Define LCD_WRAP_EN to auto-insert line-2 / line-1 address commands.
module lcd_char_writer
   import lcd_pkg::*;
#(
   parameter int T_PWR   = 750000,
   parameter int T_INIT1 = 205000,
   parameter int T_INIT2 = 5000,
   parameter int T_SU    = 2,
   parameter int T_E     = 12,
   parameter int T_NIB   = 50,
   parameter int T_CMD   = 2000,
   parameter int T_CLR   = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_in,
   input  logic       char_is_cmd,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       init_done,
   output logic [3:0] lcd_d,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw
);

   localparam logic [CNT_W-1:0] PWR_LD  = CNT_W'(T_PWR - 1);
   localparam logic [CNT_W-1:0] G_INIT1 = CNT_W'(T_INIT1);
   localparam logic [CNT_W-1:0] G_INIT2 = CNT_W'(T_INIT2);
   localparam logic [CNT_W-1:0] G_NIB   = CNT_W'(T_NIB);
   localparam logic [CNT_W-1:0] G_CMD   = CNT_W'(T_CMD);
   localparam logic [CNT_W-1:0] G_CLR   = CNT_W'(T_CLR);

   lcd_state_t       r_state;
   lcd_state_t       w_next;
   logic [CNT_W-1:0] r_pwr;
   logic [7:0]       r_byte;
   logic             r_cmd;
   logic [2:0]       r_idx;
   logic             r_init_done;

   logic             w_start;
   logic [3:0]       w_nib;
   logic             w_rs;
   logic [CNT_W-1:0] w_gap_len;
   logic             w_done;
   logic             w_tx_gap;
   logic             w_accept;
   logic             w_pwr_end;
   logic             w_lo_end;
   logic             w_ins_go;
   logic             w_pend;
   logic [7:0]       w_ins;
   logic [7:0]       w_cfg;

   assign w_accept  = (r_state == IDLE) && char_valid;
   assign w_pwr_end = (r_state == PWR_WAIT) && (r_pwr == '0);
   assign w_lo_end  = ((r_state == SEND_LO) || (r_state == WAIT)) && w_done;
   assign w_ins_go  = w_lo_end && r_init_done && w_pend;
   assign w_cfg     = cfg_cmd(r_idx[1:0]);

   always_ff @(posedge clk) begin
      if (rst) r_state <= PWR_WAIT;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         PWR_WAIT: if (w_pwr_end) w_next = INIT_NIB;
         INIT_NIB: if (w_done && r_idx == 3'd3) w_next = INIT_CFG;
         INIT_CFG: w_next = SEND_HI;
         IDLE:     if (char_valid) w_next = SEND_HI;
         SEND_HI:  if (w_done) w_next = SEND_LO;
         SEND_LO, WAIT: begin
            if (w_lo_end) begin
               if (!r_init_done && r_idx != 3'd4) w_next = INIT_CFG;
               else if (w_ins_go)                 w_next = SEND_HI;
               else                               w_next = IDLE;
            end else if (w_tx_gap) begin
               w_next = WAIT;
            end
         end
         default: w_next = PWR_WAIT;
      endcase
   end

   // Each frame is launched in the cycle that ends the previous one
   always_comb begin
      w_start   = 1'b0;
      w_nib     = '0;
      w_rs      = 1'b0;
      w_gap_len = G_CMD;
      unique case (r_state)
         PWR_WAIT: begin
            if (w_pwr_end) begin
               w_start   = 1'b1;
               w_nib     = NIB_INIT3;
               w_gap_len = G_INIT1;
            end
         end
         INIT_NIB: begin
            if (w_done && r_idx != 3'd3) begin
               w_start   = 1'b1;
               w_nib     = (r_idx == 3'd2) ? NIB_INIT2 : NIB_INIT3;
               w_gap_len = (r_idx == 3'd0) ? G_INIT2 : G_CMD;
            end
         end
         INIT_CFG: begin
            w_start   = 1'b1;
            w_nib     = w_cfg[7:4];
            w_gap_len = G_NIB;
         end
         IDLE: begin
            if (char_valid) begin
               w_start   = 1'b1;
               w_nib     = char_in[7:4];
               w_rs      = ~char_is_cmd;
               w_gap_len = G_NIB;
            end
         end
         SEND_HI: begin
            if (w_done) begin
               w_start   = 1'b1;
               w_nib     = r_byte[3:0];
               w_rs      = ~r_cmd;
               w_gap_len = (r_cmd && is_slow(r_byte)) ? G_CLR : G_CMD;
            end
         end
         SEND_LO, WAIT: begin
            if (w_ins_go) begin
               w_start   = 1'b1;
               w_nib     = w_ins[7:4];
               w_gap_len = G_NIB;
            end
         end
         default: w_start = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwr       <= PWR_LD;
         r_byte      <= '0;
         r_cmd       <= 1'b0;
         r_idx       <= '0;
         r_init_done <= 1'b0;
      end else begin
         if (r_state == PWR_WAIT && r_pwr != '0)
            r_pwr <= r_pwr - CNT_W'(1);
         if (r_state == INIT_NIB && w_done)
            r_idx <= (r_idx == 3'd3) ? 3'd0 : r_idx + 3'd1;
         if (r_state == INIT_CFG) begin
            r_byte <= w_cfg;
            r_cmd  <= 1'b1;
            r_idx  <= r_idx + 3'd1;
         end
         if (w_accept) begin
            r_byte <= char_in;
            r_cmd  <= char_is_cmd;
         end
         if (w_ins_go) begin
            r_byte <= w_ins;
            r_cmd  <= 1'b1;
         end
         if (w_next == IDLE)
            r_init_done <= 1'b1;
      end
   end

`ifdef LCD_WRAP_EN
   logic [4:0] r_col;
   logic       r_pend;
   logic [7:0] r_ins;

   // Count 16 or 32 wraps the 5-bit column through the address insert
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col  <= '0;
         r_pend <= 1'b0;
         r_ins  <= CMD_LINE1;
      end else if (w_accept) begin
         if (char_is_cmd) begin
            if (is_slow(char_in)) r_col <= '0;
         end else begin
            r_col <= r_col + 5'd1;
            if (r_col == 5'd15) begin
               r_pend <= 1'b1;
               r_ins  <= CMD_LINE2;
            end else if (r_col == 5'd31) begin
               r_pend <= 1'b1;
               r_ins  <= CMD_LINE1;
            end
         end
      end else if (w_ins_go) begin
         r_pend <= 1'b0;
      end
   end

   assign w_pend = r_pend;
   assign w_ins  = r_ins;
`else
   assign w_pend = 1'b0;
   assign w_ins  = CMD_LINE1;
`endif

   lcd_nibble_tx #(
      .T_SU (T_SU),
      .T_E  (T_E)
   ) u_tx (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_nib   (w_nib),
      .i_rs    (w_rs),
      .i_gap   (w_gap_len),
      .o_done  (w_done),
      .o_gap   (w_tx_gap),
      .o_d     (lcd_d),
      .o_e     (lcd_e),
      .o_rs    (lcd_rs)
   );

   assign char_ready = (r_state == IDLE);
   assign init_done  = r_init_done;
   assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_char_writer.sv
// tb_lcd_char_writer: directed table-driven bench for lcd_char_writer
// using short timing parameters; LCD_WRAP_EN selects wrap expectations.
module tb_lcd_char_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] char_in = '0;
   logic       char_is_cmd = 1'b0;
   logic       char_valid = 1'b0;
   logic       char_ready;
   logic       init_done;
   logic [3:0] lcd_d;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;

   always #5 clk = ~clk;

   lcd_char_writer #(
      .T_PWR(100), .T_INIT1(40), .T_INIT2(20), .T_SU(2),
      .T_E(3), .T_NIB(4), .T_CMD(10), .T_CLR(30)
   ) dut (
      .clk(clk), .rst(rst), .char_in(char_in),
      .char_is_cmd(char_is_cmd), .char_valid(char_valid),
      .char_ready(char_ready), .init_done(init_done),
      .lcd_d(lcd_d), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
   );

`ifdef LCD_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   typedef struct {
      logic [7:0] b;
      logic       cmd;
      int         lat;
   } vec_t;

   int         total = 0;
   int         bad = 0;
   int         viol = 0;
   logic [4:0] pq[$];
   logic       mon_en = 1'b0;
   logic       prev_e = 1'b0;
   logic       prev_rs = 1'b0;
   logic [3:0] prev_d = '0;

   // Record {rs,d} at each E rise and watch bus stability around E
   always @(negedge clk) begin
      if (mon_en) begin
         if (lcd_e && !prev_e) pq.push_back({lcd_rs, lcd_d});
         if (lcd_e && prev_e && lcd_d !== prev_d) viol++;
         if ((lcd_e || prev_e) && lcd_rs !== prev_rs) viol++;
      end
      prev_e  = lcd_e;
      prev_rs = lcd_rs;
      prev_d  = lcd_d;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_chk(input string nm, input logic [4:0] exp);
      logic [4:0] got;
      if (pq.size() == 0) got = 'x;
      else                got = pq.pop_front();
      chk(nm, {27'd0, got}, {27'd0, exp});
   endtask

   task automatic check_init();
      logic [4:0] init_exp [12];
      int n;
      init_exp = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                   5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
      n = 0;
      while (!lcd_e && n < 1000) begin tick(); n++; end
      chk("pwr_quiet", {31'd0, n >= 100 && n < 1000}, 32'd1);
      n = 0;
      while (!init_done && n < 2000) begin tick(); n++; end
      chk("init_done", {31'd0, init_done}, 32'd1);
      chk("ready_with_done", {31'd0, char_ready}, 32'd1);
      for (int i = 0; i < 12; i++)
         pop_chk($sformatf("init_pulse%0d", i), init_exp[i]);
      chk("init_extra", pq.size(), 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic c,
                            output int lat);
      int n;
      n = 0;
      while (!char_ready && n < 500) begin tick(); n++; end
      char_in     = b;
      char_is_cmd = c;
      char_valid  = 1'b1;
      tick();
      char_valid = 1'b0;
      lat = 0;
      while (!char_ready && lat < 500) begin tick(); lat++; end
   endtask

   initial begin
      vec_t       vt [8];
      logic [7:0] hv [5];
      int         lat;
      int         n;
      bit         ins;

      vt = '{'{8'h41, 1'b0, 24}, '{8'h01, 1'b1, 44},
             '{8'h02, 1'b1, 44}, '{8'h28, 1'b1, 24},
             '{8'hC0, 1'b1, 24}, '{8'h01, 1'b0, 24},
             '{8'hFF, 1'b0, 24}, '{8'h03, 1'b1, 24}};
      hv = '{8'h48, 8'h49, 8'h21, 8'h7E, 8'h00};

      repeat (3) tick();
      chk("rst_e", {31'd0, lcd_e}, 32'd0);
      chk("rst_d", {28'd0, lcd_d}, 32'd0);
      chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
      chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
      chk("rst_ready", {31'd0, char_ready}, 32'd0);
      chk("rst_done", {31'd0, init_done}, 32'd0);
      rst = 1'b0;
      tick();
      mon_en = 1'b1;
      check_init();

      for (int i = 0; i < 8; i++) begin
         send_byte(vt[i].b, vt[i].cmd, lat);
         chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
         pop_chk($sformatf("vec%0d_hi", i), {~vt[i].cmd, vt[i].b[7:4]});
         pop_chk($sformatf("vec%0d_lo", i), {~vt[i].cmd, vt[i].b[3:0]});
         chk($sformatf("vec%0d_extra", i), pq.size(), 0);
      end

      char_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         char_in     = hv[k];
         char_is_cmd = 1'b0;
         n = 0;
         while (!char_ready && n < 500) begin tick(); n++; end
         tick();
      end
      char_valid = 1'b0;
      n = 0;
      while (!char_ready && n < 500) begin tick(); n++; end
      repeat (5) tick();
      chk("held_count", pq.size(), 10);
      for (int k = 0; k < 5; k++) begin
         pop_chk($sformatf("held%0d_hi", k), {1'b1, hv[k][7:4]});
         pop_chk($sformatf("held%0d_lo", k), {1'b1, hv[k][3:0]});
      end

      n = 0;
      while (!char_ready && n < 500) begin tick(); n++; end
      char_in     = 8'h55;
      char_is_cmd = 1'b0;
      char_valid  = 1'b1;
      tick();
      char_valid = 1'b0;
      n = 0;
      while (!lcd_e && n < 50) begin tick(); n++; end
      chk("mid_e_seen", {31'd0, lcd_e}, 32'd1);
      rst    = 1'b1;
      mon_en = 1'b0;
      tick();
      chk("mid_rst_e", {31'd0, lcd_e}, 32'd0);
      chk("mid_rst_done", {31'd0, init_done}, 32'd0);
      chk("mid_rst_ready", {31'd0, char_ready}, 32'd0);
      rst = 1'b0;
      tick();
      pq.delete();
      mon_en = 1'b1;
      check_init();

      for (int i = 1; i <= 32; i++) begin
         send_byte(8'h30, 1'b0, lat);
         ins = WRAP && (i == 16 || i == 32);
         chk($sformatf("wrap%0d_lat", i), lat, ins ? 48 : 24);
         pop_chk($sformatf("wrap%0d_hi", i), 5'h13);
         pop_chk($sformatf("wrap%0d_lo", i), 5'h10);
         if (ins) begin
            pop_chk($sformatf("wrap%0d_ins_hi", i), (i == 16) ? 5'h0C : 5'h08);
            pop_chk($sformatf("wrap%0d_ins_lo", i), 5'h00);
         end
         chk($sformatf("wrap%0d_extra", i), pq.size(), 0);
      end

      chk("bus_stability", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lcd_char_writer.md
# lcd_char_writer

- Drives an HD44780-compatible character LCD in 4-bit, write-only mode.
- Consumes 8-bit ASCII/command bytes, such as the output of the hex-to-ASCII decode stage, through a valid/ready handshake.
- On its own, it runs the power-on initialisation sequence and then the configuration sequence.
- It then serialises each accepted byte into two nibble writes with HD44780 setup, enable-pulse and execution timing, all counted in `clk` cycles.

## Interface
Parameters:
- `T_PWR`, 750000: power-on wait cycles (15 ms @ 50 MHz).
- `T_INIT1`, 205000: wait after first init nibble (4.1 ms).
- `T_INIT2`, 5000: wait after second init nibble (100 µs).
- `T_SU`, 2: cycles `lcd_d`/`lcd_rs` are stable before `lcd_e` rises.
- `T_E`, 12: `lcd_e` high cycles.
- `T_NIB`, 50: gap after the high nibble (1 µs).
- `T_CMD`, 2000: gap after the low nibble (40 µs); also the wait after init nibbles 3 and 4.
- `T_CLR`, 82000: gap after the low nibble of command 0x01 or 0x02 (1.64 ms).

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `char_in`, in, 8: byte to write.
- `char_is_cmd`, in, 1: 1 means the byte is a command (RS=0); 0 means data (RS=1).
- `char_valid`, in, 1: byte offered.
- `char_ready`, out, 1: block can accept a byte.
- `init_done`, out, 1: high once init and configuration are complete; stays high until reset.
- `lcd_d`, out, 4: LCD data nibble (DB7..DB4).
- `lcd_e`, out, 1: enable strobe.
- `lcd_rs`, out, 1: register select.
- `lcd_rw`, out, 1: tied 0 (write-only).

## Operation
Reset values:
- All outputs are 0.
- The state machine goes to `PWR_WAIT` and all counters clear.
- Reset asserted mid-operation aborts immediately: `lcd_e` drops in the cycle after `rst` is sampled, and no partial byte is resumed.

State sequence:
- `PWR_WAIT`: wait `T_PWR` cycles.
- `INIT_NIB`: four single-nibble writes with RS=0: 0x3, 0x3, 0x3, 0x2. The waits after them are `T_INIT1`, `T_INIT2`, `T_CMD` and `T_CMD`.
- `INIT_CFG`: four command bytes, 0x28, 0x06, 0x0C, 0x01, each sent as a normal byte.
- `IDLE`: `init_done`=1 from entry, and `char_ready`=1 only in this state.
- `SEND_HI`: sends `char_in[7:4]` as a nibble frame.
- `SEND_LO`: sends `char_in[3:0]` as a nibble frame.
- `WAIT`: the post-byte gap; returns to `IDLE` when it expires.

Handshake:
- A transfer occurs on the rising edge where `char_valid && char_ready`. The byte and `char_is_cmd` are captured at that edge.
- `char_ready` deasserts in the next cycle.
- Bytes offered while `char_ready`=0 are not accepted; the upstream stage holds them.

Nibble frame:
- `lcd_d`/`lcd_rs` are driven for `T_SU` cycles.
- Then `lcd_e`=1 for `T_E` cycles.
- Then `lcd_e`=0 with data held for the gap.

Gap after a byte:
- After the high nibble: `T_NIB`.
- After the low nibble: `T_CLR` if the byte is a command equal to 0x01 or 0x02, otherwise `T_CMD`.

Counters:
- One down-counter, 20 bits wide, wide enough for `T_PWR`, loaded with N-1 for an N-cycle interval.
- Parameters of 0 are illegal.

## Timing
- Accept edge → `lcd_d`=high nibble in the next cycle.
- `lcd_e` rises `T_SU` cycles after the nibble appears.
- Byte cycle: `char_ready` returns high exactly `2·(T_SU+T_E) + T_NIB + gap_lo` cycles after the accept edge (gap_lo is the after-low-nibble gap above).
- `init_done` rises in the same cycle `char_ready` first rises.
- `lcd_rs` changes only while `lcd_e`=0.
- `lcd_d` never changes while `lcd_e`=1.

## Configuration
- Macro: `LCD_WRAP_EN`.
- Defined:
  - A 5-bit column counter increments on each accepted data byte.
  - After the data byte that makes the count 16, the block inserts command 0xC0 (line 2).
  - After the byte that makes it 32, it inserts 0x80 and the counter returns to 0.
  - `char_ready` stays 0 through the inserted command.
  - Accepted commands 0x01/0x02 clear the counter; other commands leave it unchanged.
- Undefined: no counter and no inserted commands; bytes pass through verbatim.

## Structure
- Package `lcd_pkg` holds:
  - the state enum;
  - the init nibble constants 0x3/0x2;
  - the config commands 0x28/0x06/0x0C/0x01;
  - the address commands 0x80/0xC0.
- One sub-module, `lcd_nibble_tx`:
  - inputs: start, nibble, rs, gap length;
  - behaviour: performs the setup / E-pulse / gap timing;
  - output: a one-cycle `done` pulse.
- The top level holds the sequencer and the handshake.

## Test plan
Benches override parameters to T_PWR=100, T_INIT1=40, T_INIT2=20, T_SU=2, T_E=3, T_NIB=4, T_CMD=10, T_CLR=30.
- Reset release → `lcd_e` stays 0 for 100 cycles; the first E pulse carries `lcd_d`=0x3, `lcd_rs`=0; 4 init pulses, then 8 config pulses 2,8,0,6,0,C,0,1; then `init_done`=1.
- Data 0x41 (`char_is_cmd`=0) accepted → nibbles 0x4 then 0x1 with `lcd_rs`=1; `char_ready` back high exactly 24 cycles after accept.
- Command 0x01 → `lcd_rs`=0; `char_ready` back high 44 cycles after accept.
- `char_valid` held high continuously → exactly one accept per `char_ready` window; no byte dropped or duplicated over 5 bytes.
- `rst` pulsed during `lcd_e`=1 of a data byte → `lcd_e`=0 next cycle, `init_done`=0, full init sequence replays.
- `LCD_WRAP_EN`: 16 data bytes 0x30 → 0xC0 command inserted after the 16th; 32 bytes → 0x80 inserted after the 32nd; without the macro, no insertion occurs.
